// File: rtl/uart_bus_bridge_if.sv
// bus_if: single-beat write/read bus between the UART bridge and its target
interface bus_if;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;
  modport master (output wen, waddr, wdata, ren, raddr, input rdata);
  modport slave (input wen, waddr, wdata, ren, raddr, output rdata);
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: byte-framed UART command decoder issuing single bus writes/reads
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       rx_tick
);
  logic [1:0]  sync;
  logic        busy;
  logic [15:0] cnt;
  logic [3:0]  idx;
  logic [7:0]  shreg;
  // two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clk)
    sync <= rst ? 2'b11 : {sync[0], rxd};
  // start-bit detect, mid-bit sampling of 8 data bits LSB first, tick on a good stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      rx_tick <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
    end else begin
      rx_tick <= 1'b0;
      if (!busy) begin
        busy <= !sync[1];
        cnt  <= 16'(CLKS_PER_BIT / 2);
        idx  <= '0;
      end else if (cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end else begin
        cnt <= 16'(CLKS_PER_BIT - 1);
        idx <= idx + 4'd1;
        if (idx == 4'd0) busy <= !sync[1];
        else if (idx <= 4'd8) shreg <= {sync[1], shreg[7:1]};
        else begin
          busy    <= 1'b0;
          rx_tick <= sync[1];
          data    <= shreg;
        end
      end
    end
  end
endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       txd
);
  logic [15:0] cnt;
  logic [3:0]  idx;
  logic [7:0]  shreg;
  // start bit, 8 data bits LSB first, one stop bit; busy rises the cycle after start
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      txd  <= 1'b1;
      cnt  <= '0;
      idx  <= '0;
    end else if (!busy) begin
      if (start) begin
        busy  <= 1'b1;
        txd   <= 1'b0;
        shreg <= data;
        cnt   <= 16'(CLKS_PER_BIT - 1);
        idx   <= '0;
      end
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end else if (idx == 4'd9) begin
      busy <= 1'b0;
    end else begin
      txd   <= (idx == 4'd8) ? 1'b1 : shreg[0];
      shreg <= shreg >> 1;
      idx   <= idx + 4'd1;
      cnt   <= 16'(CLKS_PER_BIT - 1);
    end
  end
endmodule

module uart_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  RxD,
  output logic  TxD,
  bus_if.master bus,
  output logic  active
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_WR, BUS_RD, RD_CAPTURE, TX_SEND, TX_WAIT} state_t;
  localparam logic [7:0] C_P = 8'h50;
  localparam logic [7:0] C_W = 8'h57;
  localparam logic [7:0] C_R = 8'h52;
  state_t      state, state_n;
  logic [7:0]  rx_data, cmd;
  logic        rx_tick, tx_start, tx_busy, wen, ren, skip, tmo_hit;
  logic [1:0]  cnt, rlen;
  logic [31:0] addr, data, reply, tmo;
  uart_rx u_rx (.clk(clk), .rst(rst), .rxd(RxD), .data(rx_data), .rx_tick(rx_tick));
  uart_tx u_tx (.clk(clk), .rst(rst), .data(reply[7:0]), .start(tx_start), .busy(tx_busy), .txd(TxD));
  assign tmo_hit   = tmo >= 32'(TIMEOUT_CYCLES);
  assign active    = state != IDLE;
  assign bus.wen   = wen;
  assign bus.ren   = ren;
  assign bus.waddr = addr;
  assign bus.raddr = addr;
  assign bus.wdata = data;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next-state and strobes; rx_tick is ignored outside IDLE/ADDR/DATA
  always_comb begin
    state_n  = state;
    wen      = 1'b0;
    ren      = 1'b0;
    tx_start = 1'b0;
    case (state)
      IDLE:       if (rx_tick) state_n = (rx_data == C_W || rx_data == C_R) ? ADDR : TX_SEND;
      ADDR: begin
        if (rx_tick && cnt == 2'd3) state_n = (cmd == C_W) ? DATA : BUS_RD;
        else if (!rx_tick && tmo_hit) state_n = IDLE;
      end
      DATA: begin
        if (rx_tick && cnt == 2'd3) state_n = BUS_WR;
        else if (!rx_tick && tmo_hit) state_n = IDLE;
      end
      BUS_WR: begin
        wen     = 1'b1;
        state_n = TX_SEND;
      end
      BUS_RD: begin
        ren     = 1'b1;
        state_n = RD_CAPTURE;
      end
      RD_CAPTURE: state_n = TX_SEND;
      TX_SEND: begin
        tx_start = !tx_busy;
        if (!tx_busy) state_n = TX_WAIT;
      end
      TX_WAIT:    if (!skip && !tx_busy) state_n = (rlen != 2'd0) ? TX_SEND : IDLE;
      default:    state_n = IDLE;
    endcase
  end
  // frame datapath: command, little-endian address/data assembly, reply shifting, timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tmo  <= '0;
      skip <= 1'b0;
    end else begin
      skip <= tx_start;
      tmo  <= (state == IDLE || rx_tick) ? '0 :
              ((state == ADDR || state == DATA) && tmo != '1) ? tmo + 32'd1 : tmo;
      case (state)
        IDLE: if (rx_tick) begin
          cmd   <= rx_data;
          cnt   <= '0;
          rlen  <= '0;
          reply <= {24'h0, (rx_data == C_P) ? 8'h4B : 8'h3F};
        end
        ADDR: if (rx_tick) begin
          addr[{cnt, 3'b000} +: 8] <= rx_data;
          cnt <= cnt + 2'd1;
        end
        DATA: if (rx_tick) begin
          data[{cnt, 3'b000} +: 8] <= rx_data;
          cnt <= cnt + 2'd1;
        end
        BUS_WR: begin
          reply <= 32'h4B;
          rlen  <= '0;
        end
        RD_CAPTURE: begin
          reply <= bus.rdata;
          rlen  <= 2'd3;
        end
        TX_WAIT: if (!skip && !tx_busy && rlen != 2'd0) begin
          rlen  <= rlen - 2'd1;
          reply <= reply >> 8;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed frames over serial RxD, decoded TxD replies and bus strobe checks
module tb_uart_bus_bridge;
  logic clk = 1'b0, rst = 1'b1, RxD = 1'b1;
  logic TxD, active;
  bus_if bus ();
  uart_bus_bridge #(.TIMEOUT_CYCLES(1000)) dut (.clk(clk), .rst(rst), .RxD(RxD), .TxD(TxD), .bus(bus), .active(active));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  int wen_cnt = 0, ren_cnt = 0, both_cnt = 0;
  int tx_base, w0, r0;
  logic [31:0] last_waddr, last_wdata, last_raddr;
  logic [7:0] txq[$];
  logic [7:0] frame[$];
  logic [7:0] mon_b;
  // bus target: rdata valid the cycle after ren, garbage otherwise
  always @(posedge clk) begin
    bus.rdata <= bus.ren ? 32'h12345678 : 32'hA5A5A5A5;
    if (bus.wen) begin
      wen_cnt    <= wen_cnt + 1;
      last_waddr <= bus.waddr;
      last_wdata <= bus.wdata;
    end
    if (bus.ren) begin
      ren_cnt    <= ren_cnt + 1;
      last_raddr <= bus.raddr;
    end
    if (bus.wen && bus.ren) both_cnt <= both_cnt + 1;
  end
  // TxD decoder sampling mid-bit
  initial forever begin
    @(posedge clk); #1;
    if (rst === 1'b0 && TxD === 1'b0) begin
      repeat (8) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(posedge clk); #1;
        mon_b[i] = TxD;
      end
      repeat (16) @(posedge clk); #1;
      txq.push_back(mon_b);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int stop_len);
    @(negedge clk) RxD = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (16) @(negedge clk);
    end
    RxD = 1'b1;
    repeat (stop_len) @(negedge clk);
  endtask
  task automatic send_frame();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 16);
  endtask
  task automatic snap();
    tx_base = txq.size();
    w0 = wen_cnt;
    r0 = ren_cnt;
  endtask
  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (txq.size() < tx_base + n && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, txq.size() - tx_base, n);
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while (active && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, active, 0);
  endtask
  function automatic logic [7:0] txb(input int i);
    return (tx_base + i < txq.size()) ? txq[tx_base + i] : 8'hxx;
  endfunction
  initial begin
    int k, lows;
    repeat (4) @(negedge clk);
    chk("rst_active", active, 0);
    chk("rst_wen", bus.wen, 0);
    chk("rst_ren", bus.ren, 0);
    chk("rst_txd", TxD, 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    snap();
    frame = {8'h50};
    send_frame();
    wait_tx(1, "ping_count");
    chk("ping_byte", txb(0), 8'h4B);
    wait_idle("ping_idle");
    chk("ping_wen", wen_cnt - w0, 0);
    chk("ping_ren", ren_cnt - r0, 0);
    snap();
    frame = {8'h57};
    send_frame();
    chk("wr_active", active, 1);
    frame = {8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame();
    wait_tx(1, "wr_count");
    chk("wr_byte", txb(0), 8'h4B);
    wait_idle("wr_idle");
    chk("wr_wen", wen_cnt - w0, 1);
    chk("wr_waddr", last_waddr, 32'h80000010);
    chk("wr_wdata", last_wdata, 32'hDEADBEEF);
    chk("wr_ren", ren_cnt - r0, 0);
    snap();
    frame = {8'h52, 8'h04, 8'h00, 8'h00, 8'h80};
    send_frame();
    wait_tx(4, "rd_count");
    chk("rd_b0", txb(0), 8'h78);
    chk("rd_b1", txb(1), 8'h56);
    chk("rd_b2", txb(2), 8'h34);
    chk("rd_b3", txb(3), 8'h12);
    wait_idle("rd_idle");
    chk("rd_ren", ren_cnt - r0, 1);
    chk("rd_raddr", last_raddr, 32'h80000004);
    chk("rd_wen", wen_cnt - w0, 0);
    chk("rd_waddr_shared", bus.waddr, 32'h80000004);
    chk("rd_wdata_held", bus.wdata, 32'hDEADBEEF);
    snap();
    frame = {8'h41};
    send_frame();
    wait_tx(1, "unk_count");
    chk("unk_byte", txb(0), 8'h3F);
    wait_idle("unk_idle");
    chk("unk_strobes", (wen_cnt - w0) + (ren_cnt - r0), 0);
    snap();
    send_byte(8'h50, 12);
    send_byte(8'h50, 16);
    wait_idle("drop_idle");
    repeat (400) @(negedge clk);
    chk("drop_count", txq.size() - tx_base, 1);
    chk("drop_byte", txb(0), 8'h4B);
    chk("drop_active", active, 0);
    snap();
    frame = {8'h57, 8'h10, 8'h00};
    send_frame();
    repeat (900) @(negedge clk);
    chk("tmo_not_early", active, 1);
    k = 0;
    while (active && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_active", active, 0);
    repeat (50) @(negedge clk);
    chk("tmo_strobes", (wen_cnt - w0) + (ren_cnt - r0), 0);
    chk("tmo_no_reply", txq.size() - tx_base, 0);
    snap();
    frame = {8'h50};
    send_frame();
    wait_tx(1, "tmo_ping_count");
    chk("tmo_ping_byte", txb(0), 8'h4B);
    wait_idle("tmo_ping_idle");
    snap();
    frame = {8'h52, 8'h04, 8'h00, 8'h00};
    send_frame();
    chk("rr_active_pre", active, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_active", active, 0);
    rst = 1'b0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (TxD !== 1'b1) lows++;
    end
    chk("rr_txd_low_cycles", lows, 0);
    chk("rr_ren", ren_cnt - r0, 0);
    chk("rr_no_reply", txq.size() - tx_base, 0);
    chk("no_wen_ren_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
